// File: rtl/sobel_filter.sv
// sobel_filter: 3-stage 3x3 Sobel edge filter with per-frame mode, 12-bit saturation
// and zeroing of windows that straddle line or frame borders.
module sobel_filter #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int DW     = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic              sof,
    input  logic [1:0]        mode,
    input  logic [3*DW-1:0]   win_top,
    input  logic [3*DW-1:0]   win_mid,
    input  logic [3*DW-1:0]   win_bot,
    output logic              out_valid,
    output logic [DW-1:0]     out_pix,
    output logic              frame_done
);
    localparam int CW = $clog2(WIDTH);
    localparam int RW = $clog2(HEIGHT);
    localparam int SW = DW + 2;
    localparam logic [SW:0] MAXV = (SW+1)'((1 << DW) - 1);

    logic [DW-1:0] t0, t1, t2, m0, m1, m2, b0, b1, b2;
    assign {t2, t1, t0} = win_top;
    assign {m2, m1, m0} = win_mid;
    assign {b2, b1, b0} = win_bot;

    function automatic logic [SW-1:0] wsum(input logic [DW-1:0] a, b, c);
        return SW'(a) + SW'({b, 1'b0}) + SW'(c);
    endfunction

    // col/row hold the position the next accepted pixel will take
    logic [CW-1:0] col, cur_col;
    logic [RW-1:0] row, cur_row;
    logic [1:0]    mode_r, cur_mode;
    logic          last_col, last_row, win_ok;
    always_comb begin
        cur_col  = sof ? '0 : col;
        cur_row  = sof ? '0 : row;
        cur_mode = sof ? mode : mode_r;
        last_col = cur_col == CW'(WIDTH - 1);
        last_row = cur_row == RW'(HEIGHT - 1);
        win_ok   = cur_row >= RW'(2) && cur_col >= CW'(2);
    end

    logic          v1, wv1, last1;
    logic [1:0]    mode1;
    logic [DW-1:0] ctr1;
    logic [SW-1:0] gxr1, gxl1, gyb1, gyt1;
    logic          v2, wv2, last2;
    logic [1:0]    mode2;
    logic [DW-1:0] ctr2;
    logic [SW-1:0] ax2, ay2;

    logic signed [SW:0] dx, dy;
    logic [SW-1:0]      ax, ay;
    logic [SW:0]        sum3, sel3;
    logic [DW-1:0]      sat3;
    always_comb begin
        dx   = $signed({1'b0, gxr1}) - $signed({1'b0, gxl1});
        dy   = $signed({1'b0, gyb1}) - $signed({1'b0, gyt1});
        ax   = SW'(dx[SW] ? -dx : dx);
        ay   = SW'(dy[SW] ? -dy : dy);
        sum3 = {1'b0, ax2} + {1'b0, ay2};
        sel3 = mode2 == 2'b00 ? {1'b0, ax2} :
               mode2 == 2'b01 ? {1'b0, ay2} :
               mode2 == 2'b10 ? sum3 : (SW+1)'(ctr2);
        sat3 = sel3 > MAXV ? {DW{1'b1}} : sel3[DW-1:0];
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            col <= '0; row <= '0; mode_r <= 2'b00;
            v1 <= 1'b0; wv1 <= 1'b0; last1 <= 1'b0; mode1 <= 2'b00; ctr1 <= '0;
            gxr1 <= '0; gxl1 <= '0; gyb1 <= '0; gyt1 <= '0;
            v2 <= 1'b0; wv2 <= 1'b0; last2 <= 1'b0; mode2 <= 2'b00; ctr2 <= '0;
            ax2 <= '0; ay2 <= '0;
            out_valid <= 1'b0; out_pix <= '0; frame_done <= 1'b0;
        end else begin
            if (in_valid) begin
                col <= last_col ? '0 : cur_col + CW'(1);
                row <= last_col ? (last_row ? '0 : cur_row + RW'(1)) : cur_row;
                if (sof) mode_r <= mode;
            end
            v1    <= in_valid;
            wv1   <= win_ok;
            last1 <= last_col && last_row;
            mode1 <= cur_mode;
            ctr1  <= m1;
            gxr1  <= wsum(t0, m0, b0);
            gxl1  <= wsum(t2, m2, b2);
            gyb1  <= wsum(b0, b1, b2);
            gyt1  <= wsum(t0, t1, t2);
            v2    <= v1;
            wv2   <= wv1;
            last2 <= last1;
            mode2 <= mode1;
            ctr2  <= ctr1;
            ax2   <= ax;
            ay2   <= ay;
            out_valid  <= v2;
            out_pix    <= wv2 ? sat3 : '0;
            frame_done <= v2 && last2;
        end
    end
endmodule

// File: doc/sobel_filter.md
# sobel_filter

Pipelined 3x3 Sobel edge stage sitting directly downstream of the 640-wide line-buffer shift register. Each cycle it consumes one 3x3 window of 12-bit grayscale pixels, computes |Gx|, |Gy| or their sum according to a per-frame mode, saturates the result to 12 bits, and emits one output pixel per accepted input. It tracks pixel position to zero out windows that straddle frame or line boundaries.

## Interface
- WIDTH, 640, pixels per line
- HEIGHT, 480, lines per frame
- DW, 12, pixel width in bits
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  window valid this cycle
- sof  in  1  start of frame; qualified by in_valid; marks pixel (row 0, col 0)
- mode  in  2  00 |Gx|, 01 |Gy|, 10 |Gx|+|Gy|, 11 centre-pixel passthrough
- win_top  in  3xDW  oldest line; [0] newest column (right), [2] oldest (left)
- win_mid  in  3xDW  middle line, same indexing
- win_bot  in  3xDW  newest line, same indexing; win_bot[0] is the pixel accepted with this in_valid
- out_valid  out  1  out_pix valid
- out_pix  out  DW  filtered pixel
- frame_done  out  1  one-cycle pulse with the output of the last pixel of a frame

## Operation
- Notation: p[r][c], r=0 top, r=2 bot; c=0 newest, c=2 oldest.
- Gx = (p[0][0]+2p[1][0]+p[2][0]) - (p[0][2]+2p[1][2]+p[2][2]) (right minus left).
- Gy = (p[2][0]+2p[2][1]+p[2][2]) - (p[0][0]+2p[0][1]+p[0][2]) (bottom minus top).
- Widths: partial sums 14 bits unsigned (max 16380); differences 15-bit signed; abs values 14 bits; |Gx|+|Gy| 15 bits (max 32760). Final result saturates to 4095; no wrap.
- Mode 11 outputs p[1][1] unchanged.
- Position counters col (0..WIDTH-1) and row (0..HEIGHT-1) track the newest pixel and advance only on in_valid.
  - in_valid && sof: col=0, row=0 for this pixel.
  - Otherwise col increments; at WIDTH-1 it wraps to 0 and row increments; at (HEIGHT-1, WIDTH-1) both wrap to 0.
- Window valid iff row>=2 && col>=2. An invalid window outputs 0, in every mode including 11; out_valid is still asserted, keeping one output per input.
- Mode register: loaded from mode on in_valid && sof and applied to that pixel onward. Mode changes mid-frame are ignored until the next sof.
- frame_done accompanies the output of the pixel at (HEIGHT-1, WIDTH-1).
- No backpressure. The pipeline advances every cycle; in_valid=0 inserts a bubble (out_valid=0 three cycles later).

## Timing
- 3-stage pipeline, latency 3: input at edge N produces out_valid/out_pix after edge N+3.
  - S1: register the six column/row sums, window-valid flag, mode, centre pixel.
  - S2: differences and abs.
  - S3: mode select, saturate, border zeroing.
- Throughput 1 pixel/cycle.
- Reset (rst=0 at a rising edge): out_valid=0, out_pix=0, frame_done=0, col=0, row=0, mode register=00, and all stage valids cleared. Outputs hold these values from the following cycle.
- Reset mid-frame discards in-flight pixels, producing no spurious out_valid. After reset, counting resumes from (0,0) on the first in_valid, whether or not sof is asserted.
- sof on a pixel whose counter is not at (0,0) resynchronises the counters immediately; no error output.

## Test plan
- Flat field: all pixels 2000, mode 10, full 640x480 frame -> every out_pix 0; 307200 out_valids; frame_done once, 3 cycles after the last input.
- Vertical edge: c=2 column 0, c=1/c=0 columns 1000, at row 5 col 10, mode 00 -> out_pix 4000 after 3 cycles. Same window in mode 01 -> 0; mode 10 -> 4000.
- Saturation: c=2 column 0, others 4095, mode 00 -> 4095 (raw 16380). Mode 10 with a diagonal edge (raw sum >4095) -> 4095.
- Borders: nonzero edge windows at (row 1, col 100) and (row 100, col 1), mode 11 -> out_pix 0 for both; at (row 2, col 2) -> centre pixel value.
- Mode latching: sof with mode 00; mode switched to 01 mid-frame on an edge window -> results still |Gx|; next sof with mode 01 -> |Gy|.
- Bubbles/reset: in_valid toggled 1,0,1 -> out_valid 1,0,1 three cycles later. rst low for one cycle with 2 pixels in flight -> out_valid 0 with no stale outputs, and the next pixel is counted as (0,0).
